// File: rtl/regfile_mp_sb_pkg.sv
// regfile_mp_sb_pkg: shared defaults, address/data types and the hardwired-zero register index
package regfile_mp_sb_pkg;
  localparam int XLEN_D = 64;
  localparam int NREG_D = 32;
  localparam int AW_D = $clog2(NREG_D);
  typedef logic [AW_D-1:0] reg_addr_t;
  typedef logic [XLEN_D-1:0] xlen_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: read, write and scoreboard bundle between decode/writeback and the register file
interface regfile_mp_sb_if #(
  parameter int XLEN = 64,
  parameter int AW = 5,
  parameter int NREAD = 2,
  parameter int NWRITE = 1
);
  logic [NREAD-1:0] ren;
  logic [NREAD*AW-1:0] raddr;
  logic [NREAD*XLEN-1:0] rdata;
  logic [NREAD-1:0] rbusy;
  logic [NWRITE-1:0] wen;
  logic [NWRITE*AW-1:0] waddr;
  logic [NWRITE*XLEN-1:0] wdata;
  logic sb_set;
  logic [AW-1:0] sb_addr;
  logic sb_flush;
  logic any_busy;
  modport master (
    output ren, raddr, wen, waddr, wdata, sb_set, sb_addr, sb_flush,
    input rdata, rbusy, any_busy
  );
  modport slave (
    input ren, raddr, wen, waddr, wdata, sb_set, sb_addr, sb_flush,
    output rdata, rbusy, any_busy
  );
endinterface

// File: rtl/regfile_mp_sb_wr_sel.sv
// regfile_wr_sel: finds whether any write port targets an address and picks the highest-index port's data
module regfile_wr_sel #(
  parameter int XLEN = 64,
  parameter int AW = 5,
  parameter int NWRITE = 1
) (
  input  logic [AW-1:0]          i_addr,
  input  logic [NWRITE-1:0]      i_wen,
  input  logic [NWRITE*AW-1:0]   i_waddr,
  input  logic [NWRITE*XLEN-1:0] i_wdata,
  output logic                   o_hit,
  output logic [XLEN-1:0]        o_data
);
  // ascending scan so a later (higher-index) match overrides an earlier one
  always_comb begin
    o_hit = 1'b0;
    o_data = '0;
    for (int j = 0; j < NWRITE; j++) begin
      if (i_wen[j] && i_waddr[j*AW +: AW] == i_addr) begin
        o_hit = 1'b1;
        o_data = i_wdata[j*XLEN +: XLEN];
      end
    end
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port integer register file with x0=0, optional write bypass and busy scoreboard
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int AW = AW_D,
  parameter int NREAD = 2,
  parameter int NWRITE = 1,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst,
  regfile_mp_sb_if.slave bus
);
  if (NREG != (1 << AW) || NREAD < 1 || NWRITE < 1) begin : g_bad_params
    $error("regfile_mp_sb: need NREG == 2**AW, NREAD >= 1, NWRITE >= 1");
  end
  logic [XLEN-1:0] r_rf [NREG];
  logic [NREG-1:0] r_busy;
  logic            w_hit [1:NREG-1];
  logic [XLEN-1:0] w_wd [1:NREG-1];
  for (genvar r = 1; r < NREG; r++) begin : g_ns
    regfile_wr_sel #(.XLEN(XLEN), .AW(AW), .NWRITE(NWRITE)) u_sel (
      .i_addr(AW'(r)),
      .i_wen(bus.wen),
      .i_waddr(bus.waddr),
      .i_wdata(bus.wdata),
      .o_hit(w_hit[r]),
      .o_data(w_wd[r])
    );
  end
  // register and busy update; x0 is never written, and a new issue (set) outranks flush and writeback clears
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) r_rf[k] <= '0;
      r_busy <= '0;
    end else begin
      for (int k = 1; k < NREG; k++) begin
        if (w_hit[k]) r_rf[k] <= w_wd[k];
        r_busy[k] <= (bus.sb_set && bus.sb_addr == AW'(k)) || (!bus.sb_flush && !w_hit[k] && r_busy[k]);
      end
    end
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   w_a;
    logic            w_en;
    logic            w_fhit;
    logic [XLEN-1:0] w_fdata;
    assign w_a = bus.raddr[i*AW +: AW];
    assign w_en = bus.ren[i] && w_a != AW'(REG_ZERO);
    regfile_wr_sel #(.XLEN(XLEN), .AW(AW), .NWRITE(NWRITE)) u_fwd (
      .i_addr(w_a),
      .i_wen(bus.wen),
      .i_waddr(bus.waddr),
      .i_wdata(bus.wdata),
      .o_hit(w_fhit),
      .o_data(w_fdata)
    );
    assign bus.rdata[i*XLEN +: XLEN] = !w_en ? '0 : (BYPASS != 0 && w_fhit) ? w_fdata : r_rf[w_a];
    assign bus.rbusy[i] = w_en && r_busy[w_a] && !(BYPASS != 0 && w_fhit);
  end
  assign bus.any_busy = |r_busy;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed scoreboard bench for a bypassing and a non-bypassing register file
module tb_regfile_mp_sb;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  typedef struct {
    int p;
    logic [63:0] d;
    logic bz;
    string tag;
  } exp_t;
  exp_t q[$];
  regfile_mp_sb_if #(.XLEN(64), .AW(5), .NREAD(2), .NWRITE(2)) b ();
  regfile_mp_sb_if #(.XLEN(64), .AW(5), .NREAD(2), .NWRITE(2)) nb ();
  assign nb.ren = b.ren;
  assign nb.raddr = b.raddr;
  assign nb.wen = b.wen;
  assign nb.waddr = b.waddr;
  assign nb.wdata = b.wdata;
  assign nb.sb_set = b.sb_set;
  assign nb.sb_addr = b.sb_addr;
  assign nb.sb_flush = b.sb_flush;
  regfile_mp_sb #(.XLEN(64), .NREG(32), .AW(5), .NREAD(2), .NWRITE(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  regfile_mp_sb #(.XLEN(64), .NREG(32), .AW(5), .NREAD(2), .NWRITE(2), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .bus(nb)
  );
  task automatic idle();
    b.ren = '0;
    b.raddr = '0;
    b.wen = '0;
    b.waddr = '0;
    b.wdata = '0;
    b.sb_set = 1'b0;
    b.sb_addr = '0;
    b.sb_flush = 1'b0;
  endtask
  task automatic rd(input int p, input logic [4:0] a);
    b.ren[p] = 1'b1;
    b.raddr[p*5 +: 5] = a;
  endtask
  task automatic wr(input int j, input logic [4:0] a, input logic [63:0] d);
    b.wen[j] = 1'b1;
    b.waddr[j*5 +: 5] = a;
    b.wdata[j*64 +: 64] = d;
  endtask
  task automatic sb(input logic [4:0] a);
    b.sb_set = 1'b1;
    b.sb_addr = a;
  endtask
  task automatic expect_rd(input int p, input logic [63:0] d, input logic bz, input string tag);
    exp_t e;
    e.p = p;
    e.d = d;
    e.bz = bz;
    e.tag = tag;
    q.push_back(e);
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, want);
    end
  endtask
  task automatic check();
    exp_t e;
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, "_data"}, b.rdata[e.p*64 +: 64], e.d);
      chk({e.tag, "_busy"}, 64'(b.rbusy[e.p]), 64'(e.bz));
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask
  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(0, 5); rd(1, 31);
    expect_rd(0, 0, 0, "rst_x5"); expect_rd(1, 0, 0, "rst_x31");
    check();
    chk("rst_any", 64'(b.any_busy), 0);
    wr(0, 5, 64'hDEAD);
    tick();
    rd(0, 5);
    expect_rd(0, 64'hDEAD, 0, "wr_x5");
    check();
    rst = 1'b1;
    wr(0, 6, 64'hBEEF); sb(6);
    tick();
    rst = 1'b0;
    rd(0, 5); rd(1, 6);
    expect_rd(0, 0, 0, "rst2_x5"); expect_rd(1, 0, 0, "rst2_x6");
    check();
    chk("rst2_any", 64'(b.any_busy), 0);
    wr(0, 0, 64'hFFFF); sb(0); rd(0, 0);
    expect_rd(0, 0, 0, "x0_same");
    check();
    tick();
    rd(0, 0);
    expect_rd(0, 0, 0, "x0_after");
    check();
    chk("x0_any", 64'(b.any_busy), 0);
    wr(0, 7, 64'h1111);
    tick();
    wr(0, 7, 64'h1234); rd(0, 7);
    expect_rd(0, 64'h1234, 0, "byp_same");
    check();
    chk("nobyp_old", nb.rdata[63:0], 64'h1111);
    tick();
    rd(0, 7);
    expect_rd(0, 64'h1234, 0, "byp_next");
    check();
    chk("nobyp_new", nb.rdata[63:0], 64'h1234);
    wr(0, 9, 64'hAAAA); wr(1, 9, 64'hBBBB); rd(1, 9);
    expect_rd(1, 64'hBBBB, 0, "dual_byp");
    check();
    chk("dual_nobyp_old", nb.rdata[127:64], 0);
    tick();
    rd(0, 9);
    expect_rd(0, 64'hBBBB, 0, "dual_after");
    check();
    sb(3); rd(0, 3);
    expect_rd(0, 0, 0, "sb_set_same");
    check();
    tick();
    rd(0, 3);
    expect_rd(0, 0, 1, "sb_busy");
    check();
    chk("sb_any", 64'(b.any_busy), 1);
    chk("nobyp_sb_busy", 64'(nb.rbusy[0]), 1);
    wr(0, 3, 64'h33); sb(3); rd(0, 3);
    expect_rd(0, 64'h33, 0, "sb_fwd");
    check();
    chk("nobyp_fwd_busy", 64'(nb.rbusy[0]), 1);
    tick();
    rd(0, 3);
    expect_rd(0, 64'h33, 1, "sb_setwins");
    check();
    wr(1, 3, 64'h44);
    tick();
    rd(0, 3);
    expect_rd(0, 64'h44, 0, "sb_clr");
    check();
    chk("sb_clr_any", 64'(b.any_busy), 0);
    sb(4);
    tick();
    sb(8);
    tick();
    rd(0, 4); rd(1, 8);
    expect_rd(0, 0, 1, "fl_pre4"); expect_rd(1, 0, 1, "fl_pre8");
    check();
    b.sb_flush = 1'b1;
    sb(8);
    tick();
    rd(0, 4); rd(1, 8);
    expect_rd(0, 0, 0, "fl_x4"); expect_rd(1, 0, 1, "fl_x8");
    check();
    chk("fl_any", 64'(b.any_busy), 1);
    b.ren = '0;
    b.raddr[4:0] = 5'd7;
    b.raddr[9:5] = 5'd8;
    expect_rd(0, 0, 0, "ren0_x7"); expect_rd(1, 0, 0, "ren0_x8");
    check();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("rst3_any", 64'(b.any_busy), 0);
    for (int k = 10; k < 18; k++) begin
      wr(k % 2, 5'(k), 64'(k) * 64'h0001_0101_0101);
      tick();
    end
    for (int k = 10; k < 18; k += 2) begin
      rd(0, 5'(k)); rd(1, 5'(k + 1));
      expect_rd(0, 64'(k) * 64'h0001_0101_0101, 0, "fill_p0");
      expect_rd(1, 64'(k + 1) * 64'h0001_0101_0101, 0, "fill_p1");
      check();
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
